// File: rtl/bp_resolve_queue.sv
// In-order queue pairing branch predictions with resolutions to train the predictor.
// Optional resolved-outcome global history enabled by BP_RESOLVE_GHIST_EN.
module bp_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int BR_W  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pred_valid,
    input  logic            pred_taken,
    input  logic [BR_W-1:0] pred_branch,
    input  logic            res_valid,
    input  logic            res_taken,
    output logic            upd_valid,
    output logic            upd_taken,
    output logic [BR_W-1:0] upd_branch,
    output logic            upd_mispredict,
    output logic            full,
    output logic            empty,
    output logic [31:0]     total_branches,
    output logic [31:0]     total_misses,
    output logic            err_overflow,
    output logic            err_underflow,
    output logic [3:0]      ghist
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0] SAT = 32'hFFFF_FFFF;

    logic [BR_W:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     br_cnt;
    logic [31:0]     miss_cnt;
    logic            do_pop;
    logic            do_push;
    logic            head_taken;
    logic [BR_W-1:0] head_branch;
    logic            mis;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign do_pop     = res_valid && !empty;
    // A pop frees a slot on the same edge, so a full queue still accepts the push
    assign do_push    = pred_valid && (!full || do_pop);
    assign {head_taken, head_branch} = mem[rd_ptr];
    assign mis        = head_taken ^ res_taken;

    assign total_branches = br_cnt;
    assign total_misses   = miss_cnt;

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= {pred_taken, pred_branch};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid      <= 1'b0;
            upd_taken      <= 1'b0;
            upd_branch     <= '0;
            upd_mispredict <= 1'b0;
            br_cnt         <= '0;
            miss_cnt       <= '0;
            err_overflow   <= 1'b0;
            err_underflow  <= 1'b0;
        end else begin
            upd_valid <= do_pop;
            if (do_pop) begin
                upd_taken      <= res_taken;
                upd_branch     <= head_branch;
                upd_mispredict <= mis;
                if (br_cnt != SAT) br_cnt <= br_cnt + 32'd1;
                if (mis && miss_cnt != SAT) miss_cnt <= miss_cnt + 32'd1;
            end
            if (pred_valid && full && !do_pop) err_overflow <= 1'b1;
            if (res_valid && empty) err_underflow <= 1'b1;
        end
    end

`ifdef BP_RESOLVE_GHIST_EN
    logic [3:0] ghist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ghist_q <= '0;
        end else if (do_pop) begin
            ghist_q <= {ghist_q[2:0], res_taken};
        end
    end

    assign ghist = ghist_q;
`else
    assign ghist = 4'b0000;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Bench for bp_resolve_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_bp_resolve_queue;

    localparam int DEPTH = 8;
    localparam int BR_W  = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            pred_valid = 1'b0;
    logic            pred_taken = 1'b0;
    logic [BR_W-1:0] pred_branch = '0;
    logic            res_valid = 1'b0;
    logic            res_taken = 1'b0;
    logic            upd_valid;
    logic            upd_taken;
    logic [BR_W-1:0] upd_branch;
    logic            upd_mispredict;
    logic            full;
    logic            empty;
    logic [31:0]     total_branches;
    logic [31:0]     total_misses;
    logic            err_overflow;
    logic            err_underflow;
    logic [3:0]      ghist;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [BR_W:0]   m_q[$];
    logic            m_uv, m_ut, m_mis, m_ovf, m_unf;
    logic [BR_W-1:0] m_ub;
    logic [31:0]     m_br, m_miss;
    logic [3:0]      m_gh;

    bp_resolve_queue #(.DEPTH(DEPTH), .BR_W(BR_W)) dut (
        .clk(clk),
        .reset(reset),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .pred_branch(pred_branch),
        .res_valid(res_valid),
        .res_taken(res_taken),
        .upd_valid(upd_valid),
        .upd_taken(upd_taken),
        .upd_branch(upd_branch),
        .upd_mispredict(upd_mispredict),
        .full(full),
        .empty(empty),
        .total_branches(total_branches),
        .total_misses(total_misses),
        .err_overflow(err_overflow),
        .err_underflow(err_underflow),
        .ghist(ghist)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_ghist(input logic [3:0] h);
`ifdef BP_RESOLVE_GHIST_EN
        return h;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic model_update();
        logic [BR_W:0] e;
        if (reset) begin
            m_q.delete();
            m_uv = 0; m_ut = 0; m_ub = '0; m_mis = 0;
            m_br = 0; m_miss = 0; m_ovf = 0; m_unf = 0; m_gh = 0;
        end else begin
            if (res_valid && m_q.size() > 0) begin
                e = m_q.pop_front();
                m_uv = 1;
                m_ut = res_taken;
                m_ub = e[BR_W-1:0];
                m_mis = (e[BR_W] != res_taken);
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                if (m_mis && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
                m_gh = {m_gh[2:0], res_taken};
            end else begin
                m_uv = 0;
                if (res_valid) m_unf = 1;
            end
            if (pred_valid) begin
                if (m_q.size() < DEPTH) m_q.push_back({pred_taken, pred_branch});
                else m_ovf = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic rst, input logic pv, input logic pt,
                         input logic [BR_W-1:0] pb, input logic rv,
                         input logic rt);
        reset = rst;
        pred_valid = pv; pred_taken = pt; pred_branch = pb;
        res_valid = rv; res_taken = rt;
        cycle();
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 2'd3, 1, 1);
        drive(1, 1, 0, 2'd1, 1, 0);
        n_cmp++;
        if ({empty, full, upd_valid, upd_taken, upd_branch, upd_mispredict}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_flags: got e%b f%b v%b t%b b%0d m%b want 1 0 0 0 0 0",
                     empty, full, upd_valid, upd_taken, upd_branch, upd_mispredict);
        end
        n_cmp++;
        if ({total_branches, total_misses, err_overflow, err_underflow, ghist} !== '0) begin
            n_bad++;
            $display("FAIL reset_counters: got br%0d ms%0d ov%b un%b gh%b want zeros",
                     total_branches, total_misses, err_overflow, err_underflow, ghist);
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_basic();
        logic [BR_W-1:0] eb [3];
        logic            em [3];
        eb = '{2'd0, 2'd1, 2'd0};
        em = '{1'b0, 1'b1, 1'b0};
        do_reset();
        drive(0, 1, 1, 2'd0, 0, 0);
        drive(0, 1, 0, 2'd1, 0, 0);
        drive(0, 1, 1, 2'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 1);
            n_cmp++;
            if ({upd_valid, upd_branch, upd_mispredict} !== {1'b1, eb[i], em[i]}) begin
                n_bad++;
                $display("FAIL basic_upd[%0d]: got v%b b%0d m%b want v1 b%0d m%b",
                         i, upd_valid, upd_branch, upd_mispredict, eb[i], em[i]);
            end
        end
        n_cmp++;
        if (total_branches !== 32'd3 || total_misses !== 32'd1) begin
            n_bad++;
            $display("FAIL basic_counts: got %0d/%0d want 3/1",
                     total_branches, total_misses);
        end
    endtask

    task automatic test_overflow();
        logic rt;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 1'(i % 2), BR_W'(i % 4), 0, 0);
            if (i == 7) begin
                n_cmp++;
                if (full !== 1'b1 || err_overflow !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ovf_full8: got full%b ovf%b want 1 0", full, err_overflow);
                end
            end
        end
        n_cmp++;
        if (full !== 1'b1 || err_overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_ninth: got full%b ovf%b want 1 1", full, err_overflow);
        end
        for (int i = 0; i < 8; i++) begin
            rt = 1'($urandom_range(0, 1));
            drive(0, 0, 0, 0, 1, rt);
            n_cmp++;
            if ({upd_valid, upd_branch, upd_mispredict}
                !== {1'b1, BR_W'(i % 4), 1'((i % 2) != int'(rt))}) begin
                n_bad++;
                $display("FAIL ovf_pop[%0d]: got v%b b%0d m%b want v1 b%0d m%b",
                         i, upd_valid, upd_branch, upd_mispredict, i % 4,
                         (i % 2) != int'(rt));
            end
        end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_drained: got empty%b want 1", empty);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive(0, 1, 1, BR_W'(i), 0, 0);
        drive(0, 1, 0, 2'd2, 1, 1);
        n_cmp++;
        if ({full, err_overflow, upd_valid, upd_branch, upd_mispredict}
            !== {1'b1, 1'b0, 1'b1, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL full_pushpop: got f%b ov%b v%b b%0d m%b want 1 0 1 0 0",
                     full, err_overflow, upd_valid, upd_branch, upd_mispredict);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        drive(0, 0, 0, 0, 1, 1);
        n_cmp++;
        if ({err_underflow, upd_valid, total_branches, total_misses}
            !== {1'b1, 1'b0, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL unf_empty: got un%b v%b br%0d ms%0d want 1 0 0 0",
                     err_underflow, upd_valid, total_branches, total_misses);
        end
        do_reset();
        drive(0, 1, 1, 2'd3, 1, 0);
        n_cmp++;
        if ({err_underflow, upd_valid, empty} !== {1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL unf_nobypass: got un%b v%b e%b want 1 0 0",
                     err_underflow, upd_valid, empty);
        end
        drive(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if ({upd_valid, upd_branch, upd_mispredict, empty} !== {1'b1, 2'd3, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL unf_later_pop: got v%b b%0d m%b e%b want 1 3 1 1",
                     upd_valid, upd_branch, upd_mispredict, empty);
        end
    endtask

    task automatic test_ghist();
        logic outc [4];
        logic [3:0] want;
        outc = '{1'b1, 1'b0, 1'b1, 1'b1};
        want = exp_ghist(4'b1011);
        do_reset();
        for (int i = 0; i < 4; i++) drive(0, 1, 1'($urandom_range(0, 1)), 2'd0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, outc[i]);
        n_cmp++;
        if (ghist !== want) begin
            n_bad++;
            $display("FAIL ghist: got %b want %b", ghist, want);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(0, 1, 0, 2'd1, 0, 0);
        drive(0, 1, 0, 2'd2, 0, 0);
        drive(0, 1, 1, 2'd3, 0, 0);
        force dut.miss_cnt = 32'hFFFF_FFFE;
        #1 release dut.miss_cnt;
        m_miss = 32'hFFFF_FFFE;
        drive(0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 1);
        n_cmp++;
        if (total_misses !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL sat_misses: got %h want ffffffff", total_misses);
        end
        force dut.br_cnt = 32'hFFFF_FFFF;
        #1 release dut.br_cnt;
        m_br = 32'hFFFF_FFFF;
        drive(0, 0, 0, 0, 1, 0);
        n_cmp++;
        if (total_branches !== 32'hFFFF_FFFF || total_misses !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL sat_hold: got br%h ms%h want ffffffff ffffffff",
                     total_branches, total_misses);
        end
        drive(0, 1, 1, 2'd1, 0, 0);
        drive(0, 1, 0, 2'd2, 1, 0);
        drive(1, 1, 1, 2'd3, 1, 1);
        n_cmp++;
        if ({empty, full, upd_valid, upd_taken, upd_branch, upd_mispredict,
             total_branches, total_misses, err_overflow, err_underflow, ghist}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0}) begin
            n_bad++;
            $display("FAIL midq_reset: got e%b f%b v%b br%0d ms%0d ov%b un%b gh%b",
                     empty, full, upd_valid, total_branches, total_misses,
                     err_overflow, err_underflow, ghist);
        end
        drive(0, 0, 0, 0, 1, 1);
        n_cmp++;
        if ({upd_valid, err_underflow} !== {1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL midq_discard: got v%b un%b want 0 1", upd_valid, err_underflow);
        end
    endtask

    task automatic test_random();
        logic [3:0] gw;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 99) < 55), 1'($urandom),
                  BR_W'($urandom), ($urandom_range(0, 99) < 50), 1'($urandom));
            n_cmp++;
            if ({upd_valid, upd_taken, upd_branch, upd_mispredict}
                !== {m_uv, m_ut, m_ub, m_mis}) begin
                n_bad++;
                $display("FAIL rnd_upd@%0d: got %b%b%0d%b want %b%b%0d%b", c,
                         upd_valid, upd_taken, upd_branch, upd_mispredict,
                         m_uv, m_ut, m_ub, m_mis);
            end
            n_cmp++;
            if (full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0)) begin
                n_bad++;
                $display("FAIL rnd_occ@%0d: got f%b e%b want occupancy %0d",
                         c, full, empty, m_q.size());
            end
            n_cmp++;
            if (total_branches !== m_br || total_misses !== m_miss) begin
                n_bad++;
                $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", c,
                         total_branches, total_misses, m_br, m_miss);
            end
            gw = exp_ghist(m_gh);
            n_cmp++;
            if ({err_overflow, err_underflow, ghist} !== {m_ovf, m_unf, gw}) begin
                n_bad++;
                $display("FAIL rnd_flags@%0d: got %b%b %b want %b%b %b", c,
                         err_overflow, err_underflow, ghist, m_ovf, m_unf, gw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_underflow();
        test_ghist();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
